// File: rtl/gio_cpu_if.sv
// CPU-side port bus and interrupt handshake between a PicoBlaze and the gio interrupt controller.
// The master modport is the CPU side and the slave modport is the controller side.
interface gio_cpu_if;
  logic [7:0] address;
  logic [7:0] value_in;
  logic       wen;
  logic       ren;
  logic [7:0] port_out;
  logic       interrupt;
  logic       int_ack;

  // interrupt is held high by the controller until the CPU answers with a one-cycle int_ack pulse.
  // wen/ren are single-cycle strobes qualified by address; there is no back-pressure.
  modport master (
    output address, value_in, wen, ren, int_ack,
    input  port_out, interrupt
  );
  modport slave (
    input  address, value_in, wen, ren, int_ack,
    output port_out, interrupt
  );
endinterface

// File: rtl/gio_int_ctrl.sv
// 8-source PicoBlaze interrupt controller: mask, priority select, vector latch and per-source ack.
// Define INTC_ROTATE_EN for round-robin priority; otherwise bit 0 has fixed highest priority.
module gio_int_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] irq_in,
  output logic [7:0] src_ack,
  output logic [1:0] state_dbg,
  gio_cpu_if.slave   cpu
);
  localparam logic [7:0] ADDR_MASK   = 8'h40;
  localparam logic [7:0] ADDR_STATUS = 8'h41;
  localparam logic [7:0] ADDR_VECTOR = 8'h42;
  localparam logic [7:0] ADDR_ACK    = 8'h43;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SERV = 2'd2, ACK = 2'd3} state_t;

  state_t     state_q, state_d;
  logic [7:0] mask_q;
  logic [7:0] req;
  logic       vec_valid_q, vec_valid_d;
  logic [2:0] vec_idx_q, vec_idx_d;
  logic       irq_q, irq_d;
  logic [7:0] src_ack_q, src_ack_d;
  logic [7:0] port_out_q;
  logic [2:0] ptr_view;
  logic [2:0] win_idx;
  logic [2:0] cand;
  logic       found;
  logic       ack_wr;

  assign req       = irq_in & mask_q;
  assign ack_wr    = cpu.wen && (cpu.address == ADDR_ACK);
  assign state_dbg = state_q;
  assign src_ack   = src_ack_q;
  assign cpu.interrupt = irq_q;
  assign cpu.port_out  = port_out_q;

`ifdef INTC_ROTATE_EN
  logic [2:0] ptr_q;
  always_ff @(posedge clk) begin
    if (rst)
      ptr_q <= 3'd0;
    else if (state_q == ACK && vec_valid_q)
      ptr_q <= vec_idx_q + 3'd1;
  end
  assign ptr_view = ptr_q;
`else
  assign ptr_view = 3'd0;
`endif

  // First requesting source found scanning upward from ptr_view, wrapping 7 -> 0.
  always_comb begin
    win_idx = 3'd0;
    cand    = 3'd0;
    found   = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cand = ptr_view + 3'(k);
      if (!found && req[cand]) begin
        win_idx = cand;
        found   = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    vec_valid_d = vec_valid_q;
    vec_idx_d   = vec_idx_q;
    irq_d       = irq_q;
    src_ack_d   = 8'h00;
    case (state_q)
      IDLE: begin
        if (req != 8'h00) begin
          irq_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (cpu.int_ack) begin
          vec_valid_d = found;
          vec_idx_d   = win_idx;
          irq_d       = 1'b0;
          state_d     = SERV;
        end else if (req == 8'h00) begin
          irq_d   = 1'b0;
          state_d = IDLE;
        end
      end
      SERV: begin
        if (ack_wr) begin
          if (vec_valid_q) src_ack_d = 8'h01 << vec_idx_q;
          state_d = ACK;
        end
      end
      ACK: begin
        vec_valid_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      vec_valid_q <= 1'b0;
      vec_idx_q   <= 3'd0;
      irq_q       <= 1'b0;
      src_ack_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      vec_valid_q <= vec_valid_d;
      vec_idx_q   <= vec_idx_d;
      irq_q       <= irq_d;
      src_ack_q   <= src_ack_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      mask_q <= 8'h00;
    else if (cpu.wen && cpu.address == ADDR_MASK)
      mask_q <= cpu.value_in;
  end

  // Read data is zero for unmatched addresses so it can be OR-combined onto in_port.
  always_ff @(posedge clk) begin
    if (rst)
      port_out_q <= 8'h00;
    else if (cpu.ren) begin
      case (cpu.address)
        ADDR_MASK:   port_out_q <= mask_q;
        ADDR_STATUS: port_out_q <= req;
        ADDR_VECTOR: port_out_q <= {vec_valid_q, ptr_view, 1'b0, vec_idx_q};
        default:     port_out_q <= 8'h00;
      endcase
    end
  end
endmodule

// File: tb/tb_gio_int_ctrl.sv
// Directed bench for gio_int_ctrl: table-driven register reads and service cycles plus corner sequences.
module tb_gio_int_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] irq_in = 8'h00;
  logic [7:0] src_ack;
  logic [1:0] state_dbg;
  int total = 0;
  int bad   = 0;

  gio_cpu_if cpu ();

  gio_int_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .irq_in    (irq_in),
    .src_ack   (src_ack),
    .state_dbg (state_dbg),
    .cpu       (cpu.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] mask;
    logic [7:0] irq;
    logic [7:0] addr;
    logic [7:0] exp;
  } rd_vec_t;

  typedef struct {
    logic [7:0] mask;
    logic [7:0] irq;
    logic [7:0] exp_vec;
    logic [7:0] exp_ack;
  } srv_vec_t;

  rd_vec_t  rd_tab[8];
  srv_vec_t srv_tab[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    irq_in = 8'h00;
    cpu.wen = 1'b0; cpu.ren = 1'b0; cpu.int_ack = 1'b0;
    cpu.address = 8'h00; cpu.value_in = 8'h00;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic bus_wr(input logic [7:0] a, input logic [7:0] d);
    cpu.address = a; cpu.value_in = d; cpu.wen = 1'b1;
    tick();
    cpu.wen = 1'b0;
  endtask

  task automatic bus_rd(input logic [7:0] a, output logic [7:0] d);
    cpu.address = a; cpu.ren = 1'b1;
    tick();
    d = cpu.port_out;
    cpu.ren = 1'b0;
  endtask

  task automatic wait_irq(input string name);
    int n;
    n = 0;
    while (cpu.interrupt !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check(name, {7'd0, cpu.interrupt}, 8'h01);
  endtask

  task automatic pulse_int_ack();
    cpu.int_ack = 1'b1;
    tick();
    cpu.int_ack = 1'b0;
  endtask

  // Full service: mask, request, CPU ack, vector read, ACK write and one-cycle source ack pulse.
  task automatic service(input string tag, input logic [7:0] m, input logic [7:0] r,
                         input logic [7:0] exp_vec, input logic [7:0] exp_ack);
    logic [7:0] d;
    bus_wr(8'h40, m);
    irq_in = r;
    wait_irq({tag, "_irq"});
    pulse_int_ack();
    check({tag, "_irq_drop"}, {7'd0, cpu.interrupt}, 8'h00);
    bus_rd(8'h42, d);
    check({tag, "_vector"}, d, exp_vec);
    bus_wr(8'h43, 8'h5A);
    check({tag, "_src_ack"}, src_ack, exp_ack);
    irq_in = irq_in & ~exp_ack;
    tick();
    check({tag, "_src_ack_end"}, src_ack, 8'h00);
    check({tag, "_idle"}, {6'd0, state_dbg}, 8'h00);
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] held;

    rd_tab[0] = '{8'h10, 8'h11, 8'h41, 8'h10};
    rd_tab[1] = '{8'hFF, 8'h28, 8'h41, 8'h28};
    rd_tab[2] = '{8'h0F, 8'hFF, 8'h41, 8'h0F};
    rd_tab[3] = '{8'h5A, 8'h00, 8'h40, 8'h5A};
    rd_tab[4] = '{8'h12, 8'h34, 8'h99, 8'h00};
    rd_tab[5] = '{8'h00, 8'hFF, 8'h41, 8'h00};
    rd_tab[6] = '{8'h00, 8'h00, 8'h42, 8'h00};
    rd_tab[7] = '{8'hA5, 8'h00, 8'h43, 8'h00};

    srv_tab[0] = '{8'h04, 8'h04, 8'h82, 8'h04};
    srv_tab[1] = '{8'hFF, 8'h28, 8'h83, 8'h08};
    srv_tab[2] = '{8'hFF, 8'h80, 8'h87, 8'h80};
    srv_tab[3] = '{8'hF0, 8'hFF, 8'h84, 8'h10};
    srv_tab[4] = '{8'hFF, 8'hFF, 8'h80, 8'h01};
    srv_tab[5] = '{8'hC0, 8'h60, 8'h86, 8'h40};

    // Reset state and masked-off requests.
    do_reset();
    check("rst_interrupt", {7'd0, cpu.interrupt}, 8'h00);
    check("rst_port_out", cpu.port_out, 8'h00);
    check("rst_src_ack", src_ack, 8'h00);
    bus_rd(8'h40, d);
    check("rst_mask", d, 8'h00);
    irq_in = 8'hFF;
    for (int i = 0; i < 5; i++) tick();
    check("mask0_no_irq", {7'd0, cpu.interrupt}, 8'h00);

    for (int i = 0; i < 8; i++) begin
      do_reset();
      bus_wr(8'h40, rd_tab[i].mask);
      irq_in = rd_tab[i].irq;
      bus_rd(rd_tab[i].addr, d);
      check($sformatf("rd_tab%0d", i), d, rd_tab[i].exp);
    end

    // Without ren the read register holds its last value.
    do_reset();
    bus_wr(8'h40, 8'hFF);
    irq_in = 8'h30;
    bus_rd(8'h41, held);
    irq_in = 8'h00;
    tick(); tick();
    check("rd_hold", cpu.port_out, held);

    // Interrupt latency: one cycle from a masked request in IDLE.
    do_reset();
    bus_wr(8'h40, 8'h04);
    irq_in = 8'h04;
    tick();
    check("irq_latency", {7'd0, cpu.interrupt}, 8'h01);

    for (int i = 0; i < 6; i++) begin
      do_reset();
      service($sformatf("srv%0d", i), srv_tab[i].mask, srv_tab[i].irq,
              srv_tab[i].exp_vec, srv_tab[i].exp_ack);
    end

    // Two back-to-back services of 8'h28: round-robin moves on to source 5.
    do_reset();
    service("rr_first", 8'hFF, 8'h28, 8'h83, 8'h08);
    irq_in = 8'h28;
`ifdef INTC_ROTATE_EN
    service("rr_second", 8'hFF, 8'h28, 8'hC5, 8'h20);
`else
    service("rr_second", 8'hFF, 8'h28, 8'h83, 8'h08);
`endif

    // Request masked away before int_ack: interrupt withdrawn, back to IDLE.
    do_reset();
    bus_wr(8'h40, 8'hFF);
    irq_in = 8'h01;
    wait_irq("wd_irq");
    bus_wr(8'h40, 8'h00);
    tick();
    check("wd_irq_drop", {7'd0, cpu.interrupt}, 8'h00);
    check("wd_idle", {6'd0, state_dbg}, 8'h00);
    check("wd_src_ack", src_ack, 8'h00);

    // Request withdrawn in the same cycle as int_ack: invalid vector, ACK write pulses nothing.
    do_reset();
    bus_wr(8'h40, 8'hFF);
    irq_in = 8'h01;
    wait_irq("inv_irq");
    irq_in = 8'h00;
    pulse_int_ack();
    check("inv_serv", {6'd0, state_dbg}, 8'h02);
    bus_rd(8'h42, d);
    check("inv_vector", d, 8'h00);
    bus_wr(8'h43, 8'h00);
    check("inv_src_ack", src_ack, 8'h00);
    tick();
    check("inv_idle", {6'd0, state_dbg}, 8'h00);

    // ACK write in IDLE is ignored.
    do_reset();
    bus_wr(8'h43, 8'hFF);
    check("idle_ack_ignored", src_ack, 8'h00);
    tick();
    check("idle_ack_state", {6'd0, state_dbg}, 8'h00);

    // Reset in SERV: everything back to reset values and no source ack ever appears.
    do_reset();
    bus_wr(8'h40, 8'h08);
    irq_in = 8'h08;
    wait_irq("rsv_irq");
    pulse_int_ack();
    cpu.address = 8'h42; cpu.ren = 1'b1;
    tick();
    cpu.ren = 1'b0;
    check("rsv_vector_pre", cpu.port_out, 8'h83);
    rst = 1'b1;
    tick();
    check("rsv_interrupt", {7'd0, cpu.interrupt}, 8'h00);
    check("rsv_port_out", cpu.port_out, 8'h00);
    check("rsv_state", {6'd0, state_dbg}, 8'h00);
    rst = 1'b0;
    bus_wr(8'h43, 8'h01);
    check("rsv_src_ack", src_ack, 8'h00);
    tick();
    check("rsv_src_ack2", src_ack, 8'h00);
    check("rsv_no_irq", {7'd0, cpu.interrupt}, 8'h00);
    bus_rd(8'h42, d);
    check("rsv_vector_post", d, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
